// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem word requests under a
// credit limit, and buffers returned words for decode with redirect flushing.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  instr_op,
  output logic [2:0]  instr_funct3,
  output logic        instr_funct7_5,
  output logic        fetch_fault
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_FAULT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_head, fifo_tail;
  logic [AW-1:0] tag_head, tag_tail;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   tag_mem   [DEPTH];

  logic          req_fire, rsp_take, rsp_keep, pop;
  logic [CW:0]   inflight;

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_take && (drop == '0) && !redirect_valid;
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};

  assign imem_req_valid = (state == S_RUN) && (inflight < {1'b0, FULL}) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = (fifo_count != '0) && !redirect_valid && (state != S_FAULT);
  assign pop         = instr_valid && instr_ready;
  assign fetch_fault = (state == S_FAULT);

  assign instr          = (fifo_count != '0) ? instr_mem[fifo_head] : '0;
  assign instr_pc       = (fifo_count != '0) ? pc_mem[fifo_head]    : '0;
  assign instr_op       = instr[6:0];
  assign instr_funct3   = instr[14:12];
  assign instr_funct7_5 = instr[30];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      fifo_head   <= '0;
      fifo_tail   <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      case (state)
        S_RESET: state <= S_RUN;
        S_RUN:   if (redirect_valid && (redirect_pc[1:0] != 2'b00)) state <= S_FAULT;
        S_FAULT: if (redirect_valid && (redirect_pc[1:0] == 2'b00)) state <= S_RUN;
        default: state <= S_RESET;
      endcase

      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (req_fire) tag_tail <= tag_tail + 1'b1;
      if (rsp_take) tag_head <= tag_head + 1'b1;

      // A redirect marks every still-outstanding request stale and empties the buffer.
      if (redirect_valid) begin
        fetch_pc   <= redirect_pc;
        drop       <= outstanding - CW'(rsp_take);
        fifo_count <= '0;
        fifo_head  <= fifo_tail;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_take && (drop != '0)) drop <= drop - 1'b1;
        fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
        if (rsp_keep) fifo_tail <= fifo_tail + 1'b1;
        if (pop)      fifo_head <= fifo_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_tail] <= fetch_pc;
    if (rsp_keep) begin
      instr_mem[fifo_tail] <= imem_rsp_data;
      pc_mem[fifo_tail]    <= tag_mem[tag_head];
    end
  end

  // The credit limit on requests must make overflow impossible.
  assert property (@(posedge clk) disable iff (rst) !(rsp_keep && (fifo_count == FULL)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order imem model plus a program-order
// reference of which PCs decode must see and which addresses must be requested.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic [6:0]  instr_op;
  logic [2:0]  instr_funct3;
  logic        instr_funct7_5;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_op(instr_op), .instr_funct3(instr_funct3), .instr_funct7_5(instr_funct7_5),
    .fetch_fault(fetch_fault)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        mq[$];
  logic [31:0] pop_log[$], req_log[$];
  int          pop_cyc[$], req_cyc[$];

  int          n_chk = 0, n_pass = 0, cyc = 0;
  int          rdy_pct, dec_pct, lat_min, lat_max;
  bit          force_dec, force_late, rst_next;
  bit          model_fault, pend_hold, rst_q, prev_iv_hold;
  logic [31:0] exp_pc, req_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_knobs(input int rdy, input int dec, input int lmin, input int lmax);
    rdy_pct = rdy; dec_pct = dec; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic clear_logs();
    pop_log.delete(); req_log.delete(); pop_cyc.delete(); req_cyc.delete();
  endtask

  // One clock cycle: drive at the falling edge, observe and advance the model before the rising edge.
  task automatic step(input bit rdr, input logic [31:0] rpc);
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    rst            = rst_next;
    redirect_valid = rdr;
    redirect_pc    = rdr ? rpc : 32'($urandom);
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready    = force_dec || ($urandom_range(99) < dec_pct);
    if (mq.size() > 0 && (mq[0].due <= cyc || force_late)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = force_late ? 32'($urandom) : mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'($urandom);
    end
    #1;
    if (rst) begin
      if (rst_q) begin
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_fields", {instr_funct7_5, instr_funct3, instr_op}, 0);
      end
      exp_pc = RESET_PC; req_pc = RESET_PC;
      model_fault = 0; pend_hold = 0; prev_iv_hold = 0; rst_q = 1;
      return;
    end
    if (rst_q) begin
      check("post_rst_req_valid", imem_req_valid, 0);
      check("post_rst_instr_valid", instr_valid, 0);
    end
    check("fault", fetch_fault, model_fault);
    if (rdr || model_fault) begin
      check("quiet_req_valid", imem_req_valid, 0);
      check("quiet_instr_valid", instr_valid, 0);
    end else if (pend_hold) begin
      check("req_hold", imem_req_valid, 1);
    end
    if (imem_req_valid) check("req_addr", imem_req_addr, req_pc);
    if (instr_valid) begin
      w = mem_word(exp_pc);
      check("instr_pc", instr_pc, exp_pc);
      check("instr", instr, w);
      check("instr_op", 32'(instr_op), 32'(w[6:0]));
      check("instr_funct3", 32'(instr_funct3), 32'(w[14:12]));
      check("instr_funct7_5", 32'(instr_funct7_5), 32'(w[30]));
      if (instr_ready) begin
        pop_log.push_back(exp_pc); pop_cyc.push_back(cyc);
        exp_pc += 32'd4;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("credit", 32'(mq.size() < DEPTH), 1);
      mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      req_log.push_back(imem_req_addr); req_cyc.push_back(cyc);
      req_pc += 32'd4;
    end
    if (rdr) begin
      exp_pc = rpc; req_pc = rpc;
      model_fault = (rpc[1:0] != 2'b00);
    end
    pend_hold    = imem_req_valid && !imem_req_ready && !rdr;
    prev_iv_hold = instr_valid && !instr_ready;
    rst_q        = 0;
  endtask

  task automatic do_reset(input bit late);
    rst_next = 1; step(0, 0); step(0, 0);
    rst_next = 0; clear_logs();
    force_late = late; step(0, 0); force_late = 0;
    mq.delete();
  endtask

  task automatic run_until(input int npop, input int nreq, input int max, input string tag);
    int n = 0;
    while ((pop_log.size() < npop || req_log.size() < nreq) && n < max) begin
      step(0, 0); n++;
    end
    check({tag, "_in_time"}, 32'(pop_log.size() >= npop && req_log.size() >= nreq), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] t;
    rst = 1; rst_next = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0; force_dec = 0; force_late = 0;
    exp_pc = RESET_PC; req_pc = RESET_PC; model_fault = 0; pend_hold = 0; rst_q = 0; prev_iv_hold = 0;

    // Boot: sequential fetch from the reset PC, one-cycle memory.
    set_knobs(100, 100, 1, 1);
    do_reset(0);
    run_until(3, 1, 30, "boot");
    check("boot_req0", req_log[0], 32'h0);
    check("boot_pc0", pop_log[0], 32'h0);
    check("boot_pc1", pop_log[1], 32'h4);
    check("boot_pc2", pop_log[2], 32'h8);
    check("boot_latency", 32'(pop_cyc[0] - req_cyc[0]), 2);

    // Decode stall: credit stops requests at DEPTH.
    set_knobs(100, 0, 1, 1);
    do_reset(0);
    repeat (10) step(0, 0);
    check("stall_reqs", 32'(req_log.size()), 2);
    check("stall_req_valid", imem_req_valid, 0);
    check("stall_req1", req_log[1], 32'h4);
    dec_pct = 100;
    run_until(2, 3, 30, "stall_drain");
    check("stall_pop0", pop_log[0], 32'h0);
    check("stall_pop1", pop_log[1], 32'h4);
    check("stall_resume", req_log[2], 32'h8);

    // Redirect with 0x8 and 0xC in flight.
    set_knobs(100, 100, 3, 3);
    do_reset(0);
    n = 0;
    while (!(mq.size() == 2 && mq[0].addr == 32'h8 && mq[1].addr == 32'hC) && n < 60) begin
      step(0, 0); n++;
    end
    check("rdr_setup", 32'(mq.size() == 2), 1);
    clear_logs();
    step(1, 32'h100);
    run_until(3, 2, 40, "rdr");
    check("rdr_pop0", pop_log[0], 32'h100);
    check("rdr_pop1", pop_log[1], 32'h104);
    check("rdr_pop2", pop_log[2], 32'h108);
    check("rdr_req1", req_log[1], 32'h104);

    // Redirect colliding with a response and a decode-ready cycle.
    set_knobs(100, 50, 1, 3);
    n = 0;
    while (!(prev_iv_hold && mq.size() > 0 && mq[0].due <= cyc + 1) && n < 300) begin
      step(0, 0); n++;
    end
    check("collide_setup", 32'(prev_iv_hold), 1);
    clear_logs();
    force_dec = 1; step(1, 32'h500); force_dec = 0;
    run_until(2, 0, 80, "collide");
    check("collide_pop0", pop_log[0], 32'h500);
    check("collide_pop1", pop_log[1], 32'h504);

    // Back-to-back redirects: the last one wins.
    clear_logs();
    step(1, 32'h300); step(1, 32'h400);
    run_until(1, 1, 80, "b2b");
    check("b2b_req0", req_log[0], 32'h400);
    check("b2b_pop0", pop_log[0], 32'h400);

    // Misaligned redirect halts fetch until an aligned one.
    set_knobs(100, 100, 1, 3);
    clear_logs();
    step(1, 32'h102);
    repeat (8) step(0, 0);
    check("fault_flag", fetch_fault, 1);
    check("fault_no_req", 32'(req_log.size()), 0);
    check("fault_no_instr", 32'(pop_log.size()), 0);
    step(1, 32'h200);
    run_until(1, 1, 40, "unfault");
    check("unfault_req0", req_log[0], 32'h200);
    check("unfault_pop0", pop_log[0], 32'h200);
    check("unfault_flag", fetch_fault, 0);

    // PC wrap.
    clear_logs();
    step(1, 32'hFFFF_FFFC);
    run_until(2, 2, 40, "wrap");
    check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
    check("wrap_req1", req_log[1], 32'h0);
    check("wrap_pop1", pop_log[1], 32'h0);

    // Reset with requests in flight; a straggler arrives after reset.
    set_knobs(100, 100, 6, 6);
    n = 0;
    while (mq.size() < 2 && n < 40) begin
      step(0, 0); n++;
    end
    check("midrst_setup", 32'(mq.size()), 2);
    do_reset(1);
    set_knobs(100, 100, 1, 2);
    run_until(2, 1, 40, "midrst");
    check("midrst_req0", req_log[0], RESET_PC);
    check("midrst_pop0", pop_log[0], RESET_PC);
    check("midrst_pop1", pop_log[1], RESET_PC + 32'd4);

    // Random traffic with random redirects.
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0)
        set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)), 1, int'($urandom_range(5, 1)));
      if ($urandom_range(99) < 3) begin
        t = 32'($urandom);
        if ($urandom_range(9) < 2) t[1:0] = 2'($urandom_range(3, 1));
        else if ($urandom_range(9) == 0) t = 32'hFFFF_FFF8;
        else t[1:0] = 2'b00;
        step(1, t);
      end else begin
        step(0, 0);
      end
    end
    check("random_progress", 32'(pop_log.size() > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with fixed in-order responses.
- Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake, with the op/funct3/funct7_5 fields pre-sliced.
- Accepts PC redirects from the execute/branch stage and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
DEPTH, 2, instruction FIFO entries and maximum outstanding requests; power of two, 2..8.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  instruction memory accepts the request.
imem_req_addr  out  32  word-aligned fetch address.
imem_rsp_valid  in  1  response valid; in order; at least 1 cycle after the request handshake.
imem_rsp_data  in  32  instruction word.
redirect_valid  in  1  one-cycle PC redirect (jump or taken branch).
redirect_pc  in  32  redirect target.
instr_valid  out  1  instruction available to decode.
instr_ready  in  1  decode consumes the instruction.
instr  out  32  instruction word.
instr_pc  out  32  PC of instr.
instr_op  out  7  instr[6:0].
instr_funct3  out  3  instr[14:12].
instr_funct7_5  out  1  instr[30].
fetch_fault  out  1  misaligned redirect seen; fetching halted.

Behaviour:
- Reset (rst high at an edge):
  - Sets state RESET, fetch_pc=RESET_PC, outstanding=0, drop=0, and empties the FIFO.
  - Outputs during and after reset: imem_req_valid=0, instr_valid=0, fetch_fault=0; imem_req_addr=RESET_PC; instr, instr_pc and the sliced fields read 0.
  - Reset mid-operation discards all in-flight responses. Any response arriving after reset with outstanding==0 is ignored.
- FSM:
  - RESET goes to RUN after exactly one cycle.
  - RUN goes to FAULT on a redirect with redirect_pc[1:0]!=0.
  - FAULT goes to RUN on an aligned redirect and stays in FAULT on a misaligned one.
- Requests, in RUN only:
  - imem_req_valid = (outstanding + fifo_count < DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC to 0), outstanding += 1.
  - Once asserted, valid and addr are held until ready. The single exception is a redirect cycle, where valid is withdrawn.
- Responses:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0, the response is discarded and drop -= 1.
  - Otherwise {data, pc} is pushed into the FIFO. The pushed PC comes from a PC queue tagging each outstanding request.
  - The credit rule guarantees no FIFO overflow. A push while full is an assertion failure.
- Decode side:
  - instr_valid = fifo non-empty && !redirect_valid && state!=FAULT.
  - The outputs show the FIFO head, with the fields sliced combinationally from instr.
  - The head pops on instr_valid && instr_ready.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - Empty FIFO with a response arriving: the instruction appears on instr_valid the next cycle; there is no bypass. Latency from request handshake to instr_valid is rsp latency + 1 cycle.
- Redirect (redirect_valid high), which takes priority over every other event that cycle:
  - Flushes the FIFO and sets fetch_pc=redirect_pc.
  - Sets drop = outstanding − (1 if a non-dropped response arrives this cycle, else 0). When drop>0 already, drop = outstanding − (rsp_valid ? 1 : 0).
  - No pop occurs on a redirect cycle.
  - A misaligned target asserts fetch_fault from the next cycle, held until an aligned redirect. In FAULT, no requests are issued; responses are still drained and dropped.
- Back-to-back redirects: the last one wins, and each recomputes drop.
- New requests may issue while drop>0. In-order return guarantees the dropped responses arrive first.

Test Plan:
- Reset sequence -> all outputs 0 during rst; the first imem_req_addr=0x0 two cycles after rst falls. With memory always ready at 1-cycle latency, instrs at PCs 0x0, 0x4, 0x8 appear in order with matching instr_op.
- Decode stall: instr_ready=0 for 10 cycles with DEPTH=2 -> exactly 2 requests issued, imem_req_valid=0 afterwards, no data lost; releasing ready drains 0x0 and 0x4, then fetching resumes at 0x8.
- Redirect to 0x100 with 2 requests outstanding (PCs 0x8, 0xC) -> both responses dropped; the next instr_pc presented is 0x100; fetch_pc sequence continues 0x104, 0x108.
- Redirect in the same cycle as a response and a decode handshake -> no pop, FIFO flushed, drop count correct; only redirect-target instructions appear afterwards.
- Misaligned redirect to 0x102 -> fetch_fault=1 next cycle, no requests and instr_valid=0; a later redirect to 0x200 clears the fault and fetches 0x200.
- Wrap and mid-run reset: redirect to 0xFFFF_FFFC -> the next request addr is 0x0. Asserting rst with requests outstanding -> late responses are ignored and fetch restarts at RESET_PC.
